// File: rtl/bht_access_ctrl.sv
// Single-port branch history table controller: arbitrates fetch predict lookups
// against queued resolve-side counter updates and sweeps the table clear after reset/flush.
module bht_access_ctrl #(
  parameter int unsigned AW        = 10,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned MAX_DEFER = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          pred_valid,
  input  logic [AW-1:0] pred_addr,
  output logic          pred_ready,
  output logic          pred_resp_valid,
  output logic          pred_taken,
  output logic [1:0]    pred_ctr,
  input  logic          upd_valid,
  input  logic [AW-1:0] upd_addr,
  input  logic          upd_taken,
  output logic          upd_ready,
  output logic          init_busy,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [1:0]    mem_wd,
  input  logic [1:0]    mem_rd
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned DW = $clog2(MAX_DEFER + 1);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t          state, state_next;
  logic [AW-1:0]   idx;
  logic [AW-1:0]   q_addr [DEPTH];
  logic [DEPTH-1:0] q_taken;
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   count;
  logic [DW-1:0]   defer;

  logic empty, full, force_upd, grant, issue, push;

  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    logic [1:0] n;
    n = 2'b00;
    case (ctr)
      2'b00: n = taken ? 2'b01 : 2'b00;
      2'b01: n = taken ? 2'b11 : 2'b00;
      2'b10: n = taken ? 2'b11 : 2'b00;
      2'b11: n = taken ? 2'b11 : 2'b10;
      default: n = 2'b00;
    endcase
    return n;
  endfunction

  assign empty     = (count == '0);
  assign full      = (count == CW'(DEPTH));
  assign force_upd = !empty && (full || (defer >= DW'(MAX_DEFER)));
  assign init_busy = (state == S_INIT);
  assign push      = upd_valid && upd_ready && !flush;

  always_comb begin
    state_next = state;
    pred_ready = 1'b0;
    upd_ready  = 1'b0;
    mem_addr   = pred_addr;
    mem_we     = 1'b0;
    mem_wd     = '0;
    grant      = 1'b0;
    issue      = 1'b0;
    case (state)
      S_INIT: begin
        mem_addr = idx;
        mem_we   = 1'b1;
        if (!flush && (idx == '1)) state_next = S_RUN;
      end
      S_RUN: begin
        pred_ready = !force_upd;
        upd_ready  = !full;
        grant      = pred_valid && !force_upd;
        if (!grant && !empty) begin
          issue    = 1'b1;
          mem_addr = q_addr[rd_ptr];
          // A flush cancels the head write even though the port was granted to it.
          mem_we   = !flush;
          mem_wd   = ctr_next(mem_rd, q_taken[rd_ptr]);
        end
        if (flush) state_next = S_INIT;
      end
      default: state_next = S_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_INIT;
      idx             <= '0;
      rd_ptr          <= '0;
      wr_ptr          <= '0;
      count           <= '0;
      defer           <= '0;
      pred_resp_valid <= 1'b0;
      pred_taken      <= 1'b0;
      pred_ctr        <= '0;
    end else begin
      state <= state_next;
      if ((state == S_INIT) && !flush) idx <= idx + AW'(1);
      else                             idx <= '0;

      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push)  wr_ptr <= wr_ptr + PW'(1);
        if (issue) rd_ptr <= rd_ptr + PW'(1);
        if (push && !issue)      count <= count + CW'(1);
        else if (!push && issue) count <= count - CW'(1);
      end

      if (flush || empty || issue)             defer <= '0;
      else if (grant && (defer != DW'(MAX_DEFER))) defer <= defer + DW'(1);

      pred_resp_valid <= grant;
      if (grant) begin
        pred_ctr   <= mem_rd;
        pred_taken <= mem_rd[1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[wr_ptr]  <= upd_addr;
      q_taken[wr_ptr] <= upd_taken;
    end
  end

endmodule

// File: tb/tb_bht_access_ctrl.sv
// Directed bench for bht_access_ctrl with AW=4: vector table for the run-mode
// arbitration/counter walk, plus hand sequences for defer, fill, flush and reset.
module tb_bht_access_ctrl;

  logic       clk = 1'b0;
  logic       rst, flush, pred_valid, upd_valid, upd_taken;
  logic [3:0] pred_addr, upd_addr, mem_addr;
  logic       pred_ready, pred_resp_valid, pred_taken, upd_ready, init_busy, mem_we;
  logic [1:0] pred_ctr, mem_wd, mem_rd;
  logic [1:0] tbl [16];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bht_access_ctrl #(.AW(4), .DEPTH(4), .MAX_DEFER(8)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .pred_valid(pred_valid), .pred_addr(pred_addr), .pred_ready(pred_ready),
    .pred_resp_valid(pred_resp_valid), .pred_taken(pred_taken), .pred_ctr(pred_ctr),
    .upd_valid(upd_valid), .upd_addr(upd_addr), .upd_taken(upd_taken), .upd_ready(upd_ready),
    .init_busy(init_busy), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wd(mem_wd),
    .mem_rd(mem_rd)
  );

  always @(posedge clk) if (mem_we) tbl[mem_addr] <= mem_wd;
  assign mem_rd = tbl[mem_addr];

  typedef struct {
    logic       pv;
    logic [3:0] pa;
    logic       uv;
    logic [3:0] ua;
    logic       ut;
    logic       e_we;
    logic [3:0] e_addr;
    logic [1:0] e_wd;
    logic       e_rv;
    logic [1:0] e_ctr;
  } vec_t;

  vec_t vec [21];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pred_valid = 1'b0; pred_addr = '0;
    upd_valid = 1'b0; upd_addr = '0; upd_taken = 1'b0;
    flush = 1'b0;
  endtask

  task automatic sweep(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      #1;
      chk("sweep_busy", init_busy, 1);
      chk("sweep_we", mem_we, 1);
      chk("sweep_wd", mem_wd, 0);
      chk("sweep_addr", mem_addr, i);
      chk("sweep_pred_ready", pred_ready, 0);
      chk("sweep_upd_ready", upd_ready, 0);
      tick();
    end
  endtask

  initial begin
    //          pv pa  uv ua  ut  we addr wd  rv ctr
    vec[0]  = '{1, 5,  0, 0,  0,  0, 5,   0,  0, 0};
    vec[1]  = '{0, 0,  1, 5,  1,  0, 0,   0,  1, 0};
    vec[2]  = '{0, 0,  1, 5,  1,  1, 5,   1,  0, 0};
    vec[3]  = '{0, 0,  0, 0,  0,  1, 5,   3,  0, 0};
    vec[4]  = '{1, 5,  0, 0,  0,  0, 5,   0,  0, 0};
    vec[5]  = '{0, 0,  1, 5,  0,  0, 0,   0,  1, 3};
    vec[6]  = '{0, 0,  1, 5,  0,  1, 5,   2,  0, 0};
    vec[7]  = '{0, 0,  0, 0,  0,  1, 5,   0,  0, 0};
    vec[8]  = '{1, 5,  0, 0,  0,  0, 5,   0,  0, 0};
    vec[9]  = '{0, 0,  1, 9,  1,  0, 0,   0,  1, 0};
    vec[10] = '{0, 0,  1, 9,  1,  1, 9,   1,  0, 0};
    vec[11] = '{0, 0,  1, 9,  1,  1, 9,   3,  0, 0};
    vec[12] = '{0, 0,  1, 9,  0,  1, 9,   3,  0, 0};
    vec[13] = '{0, 0,  1, 9,  1,  1, 9,   2,  0, 0};
    vec[14] = '{0, 0,  1, 3,  0,  1, 9,   3,  0, 0};
    vec[15] = '{0, 0,  0, 0,  0,  1, 3,   0,  0, 0};
    vec[16] = '{0, 0,  1, 7,  1,  0, 0,   0,  0, 0};
    vec[17] = '{1, 7,  0, 0,  0,  0, 7,   0,  0, 0};
    vec[18] = '{0, 0,  0, 0,  0,  1, 7,   1,  1, 0};
    vec[19] = '{1, 7,  0, 0,  0,  0, 7,   0,  0, 0};
    vec[20] = '{0, 0,  0, 0,  0,  0, 0,   0,  1, 1};

    idle();
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_resp_valid", pred_resp_valid, 0);
    chk("rst_pred_ctr", pred_ctr, 0);
    chk("rst_pred_taken", pred_taken, 0);
    chk("rst_init_busy", init_busy, 1);
    rst = 1'b0;

    sweep(16);
    #1;
    chk("post_init_busy", init_busy, 0);
    chk("post_init_pred_ready", pred_ready, 1);
    chk("post_init_upd_ready", upd_ready, 1);

    for (int i = 0; i < 21; i++) begin
      pred_valid = vec[i].pv; pred_addr = vec[i].pa;
      upd_valid = vec[i].uv; upd_addr = vec[i].ua; upd_taken = vec[i].ut;
      #1;
      chk($sformatf("v%0d_pred_ready", i), pred_ready, 1);
      chk($sformatf("v%0d_upd_ready", i), upd_ready, 1);
      chk($sformatf("v%0d_mem_we", i), mem_we, vec[i].e_we);
      chk($sformatf("v%0d_mem_addr", i), mem_addr, vec[i].e_addr);
      if (vec[i].e_we) chk($sformatf("v%0d_mem_wd", i), mem_wd, vec[i].e_wd);
      chk($sformatf("v%0d_resp_valid", i), pred_resp_valid, vec[i].e_rv);
      if (vec[i].e_rv) begin
        chk($sformatf("v%0d_pred_ctr", i), pred_ctr, vec[i].e_ctr);
        chk($sformatf("v%0d_pred_taken", i), pred_taken, vec[i].e_ctr[1]);
      end
      tick();
    end
    idle();

    // One queued update held off by continuous predicts for exactly 8 cycles.
    pred_valid = 1'b1; pred_addr = 4'd2;
    upd_valid = 1'b1; upd_addr = 4'd2; upd_taken = 1'b1;
    tick();
    upd_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk($sformatf("defer%0d_pred_ready", i), pred_ready, 1);
      chk($sformatf("defer%0d_mem_we", i), mem_we, 0);
      tick();
    end
    #1;
    chk("defer_force_pred_ready", pred_ready, 0);
    chk("defer_force_we", mem_we, 1);
    chk("defer_force_addr", mem_addr, 2);
    chk("defer_force_wd", mem_wd, 1);
    tick();
    #1;
    chk("defer_after_pred_ready", pred_ready, 1);
    chk("defer_after_we", mem_we, 0);
    idle();
    tick();

    // Fill the FIFO under continuous predicts; the full-cycle push must be dropped.
    pred_valid = 1'b1; pred_addr = 4'd0;
    upd_valid = 1'b1; upd_addr = 4'd4; upd_taken = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("fill%0d_upd_ready", i), upd_ready, 1);
      chk($sformatf("fill%0d_pred_ready", i), pred_ready, 1);
      tick();
    end
    #1;
    chk("full_upd_ready", upd_ready, 0);
    chk("full_pred_ready", pred_ready, 0);
    chk("full_we", mem_we, 1);
    chk("full_addr", mem_addr, 4);
    chk("full_wd", mem_wd, 1);
    tick();
    upd_valid = 1'b0;
    #1;
    chk("unfull_pred_ready", pred_ready, 1);
    chk("unfull_upd_ready", upd_ready, 1);
    chk("unfull_we", mem_we, 0);
    tick();
    pred_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("drain%0d_we", i), mem_we, 1);
      chk($sformatf("drain%0d_addr", i), mem_addr, 4);
      chk($sformatf("drain%0d_wd", i), mem_wd, 3);
      tick();
    end
    #1;
    chk("drained_we", mem_we, 0);
    idle();
    tick();

    // Queue 3 updates, flush: head write suppressed, then sweep; rst mid-sweep restarts it.
    pred_valid = 1'b1; pred_addr = 4'd0;
    upd_valid = 1'b1; upd_addr = 4'd8; upd_taken = 1'b1;
    repeat (3) tick();
    pred_valid = 1'b0; upd_valid = 1'b0; flush = 1'b1;
    #1;
    chk("flush_we", mem_we, 0);
    chk("flush_busy", init_busy, 0);
    tick();
    flush = 1'b0;
    sweep(6);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sweep(16);
    #1;
    chk("reinit_busy", init_busy, 0);
    chk("reinit_we", mem_we, 0);
    chk("reinit_pred_ready", pred_ready, 1);

    // A grant in the flush cycle still produces its response.
    pred_valid = 1'b1; pred_addr = 4'd5; flush = 1'b1;
    tick();
    idle();
    #1;
    chk("flush_grant_resp_valid", pred_resp_valid, 1);
    chk("flush_grant_ctr", pred_ctr, 0);
    chk("flush_grant_busy", init_busy, 1);
    tick();
    chk("flush_grant_resp_clear", pred_resp_valid, 0);
    repeat (16) tick();
    #1;
    chk("final_busy", init_busy, 0);
    chk("final_we", mem_we, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/bht_access_ctrl.md
Name: bht_access_ctrl

Overview:
- Controller that owns the single port of one 2-bit-counter branch history table (combinational read, write on posedge).
- Shares that port between two requesters:
  - the fetch-side predict lookup;
  - the resolve-side counter update. Updates are buffered in a small FIFO and applied as single-cycle read-modify-write.
- Also sequences table initialisation after reset and after flush.

Parameters:
AW, 10, table address width; the table has 2^AW entries
DEPTH, 4, update FIFO depth (power of 2, at least 2)
MAX_DEFER, 8, maximum cycles a non-empty FIFO head may be blocked by predicts before the update is forced

Ports:
clk  in  1  clock, all state changes on posedge
rst  in  1  synchronous, active-high reset
flush  in  1  one-cycle pulse: discard queued updates and re-initialise the table
pred_valid  in  1  predict lookup request
pred_addr  in  AW  lookup index
pred_ready  out  1  lookup accepted this cycle when pred_valid && pred_ready
pred_resp_valid  out  1  registered; response valid, one cycle after acceptance
pred_taken  out  1  registered; prediction = counter[1]
pred_ctr  out  2  registered; raw counter value read
upd_valid  in  1  resolved-branch update request
upd_addr  in  AW  update index
upd_taken  in  1  actual outcome
upd_ready  out  1  FIFO can accept an update
init_busy  out  1  high while the init sweep runs
mem_addr  out  AW  table address
mem_we  out  1  table write enable
mem_wd  out  2  table write data
mem_rd  in  2  table read data (combinational on mem_addr)

Behaviour:
- States: INIT, RUN.
- rst (any state, including mid-sweep) -> INIT:
  - sweep index = 0, FIFO emptied, defer counter = 0;
  - pred_resp_valid=0, pred_taken=0, pred_ctr=00.
- INIT:
  - each cycle: mem_addr = sweep index, mem_we=1, mem_wd=00; index increments;
  - after writing entry 2^AW-1 -> RUN. The sweep takes exactly 2^AW cycles;
  - init_busy=1, pred_ready=0, upd_ready=0 throughout.
- RUN, port arbitration per cycle:
  - force_upd = FIFO non-empty && (FIFO full || defer >= MAX_DEFER).
  - pred_ready = !force_upd.
  - Predict wins when pred_valid && pred_ready:
    - mem_addr = pred_addr, mem_we=0;
    - next cycle: pred_resp_valid=1, pred_ctr=mem_rd sampled at grant, pred_taken=mem_rd[1].
    - pred_resp_valid=0 in any cycle after a non-grant.
  - Otherwise, if the FIFO is non-empty, the head update issues:
    - mem_addr = head addr, mem_we=1, mem_wd = next(mem_rd, head taken); head popped. One update per cycle.
  - Otherwise: mem_we=0, mem_addr = pred_addr.
- Defer counter:
  - increments, saturating at MAX_DEFER, on each cycle the FIFO is non-empty and a predict wins;
  - clears on every update issue and whenever the FIFO is empty.
- Counter next-state (current ctr, taken -> next):
  - 00 with NT -> 00; 00 with T -> 01
  - 01 with NT -> 00; 01 with T -> 11
  - 10 with NT -> 00; 10 with T -> 11
  - 11 with NT -> 10; 11 with T -> 11
- FIFO:
  - upd_ready = RUN && count < DEPTH. Acceptance is based on the pre-pop count; there is no same-cycle bypass when full.
  - Simultaneous push and pop: count unchanged.
  - Read and write pointers wrap modulo DEPTH.
- No forwarding:
  - a predict of an address with a pending queued update returns the stale table value;
  - two queued updates to one address apply in FIFO order, each reading the prior write's result.
- flush in RUN:
  - FIFO emptied, defer = 0, -> INIT with index 0; the in-flight update that cycle is not written;
  - a response registered from a grant in the flush cycle still appears next cycle.
- flush in INIT: sweep restarts at index 0.
- rst has priority over flush.

Test Plan:
- AW=4: release rst -> init_busy=1 for exactly 16 cycles, mem_we=1 with mem_wd=00 for addresses 0..15 in order; pred_ready first high on cycle 17.
- After init, predict addr 5 -> next cycle pred_resp_valid=1, pred_ctr=00, pred_taken=0.
- Updates to addr 5 in the order T, T, NT, NT, with predicts idle -> table walks 01, 11, 10, 00; a predict after the second update returns ctr=11, taken=1.
- pred_valid held high continuously while 4 updates are pushed -> FIFO fills, upd_ready=0, pred_ready drops, one update per cycle drains the FIFO, and pred_ready returns once the FIFO is no longer full.
- One update queued under continuous pred_valid -> predicts win for exactly MAX_DEFER=8 cycles, then the update is forced (pred_ready=0 for 1 cycle).
- Queue 3 updates, assert flush -> no further update writes occur, and a 16-cycle init sweep follows; rst asserted mid-sweep restarts at index 0.
